comparator_bist: RTL and testbench

- Synthesizable built-in self-test driver for the combinational magnitude comparator. It sits on the opposite end of that block's interface.
- Generates every (a, b) operand pair.
- Samples the comparator's lt/gt/eq outputs and checks them against an internally computed golden result.
- Reports pass/fail, the error count and the first failing vector. Intended for on-chip or lab bring-up wrappers.

---
 rtl/comparator_bist.sv | 146 ++++++++++++++
 tb/tb_comparator_bist.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_bist.sv
// Exhaustive BIST driver for a combinational magnitude comparator: sweeps every (a,b) pair and checks lt/gt/eq.
// Latency: done rises 2^(2*WIDTH)*(SETTLE+1) edges after the accepted start edge (earlier on first fail if stop-on-fail).
// Backpressure: none; start is honoured only in IDLE/DONE. Optional macro COMPARATOR_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module comparator_bist #(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1
) (
    input  logic                 i_w_clk,
    input  logic                 i_w_reset,
    input  logic                 i_w_start,
    output logic [WIDTH-1:0]     o_w_a,
    output logic [WIDTH-1:0]     o_w_b,
    input  logic                 i_w_lt,
    input  logic                 i_w_gt,
    input  logic                 i_w_eq,
    output logic                 o_w_busy,
    output logic                 o_w_done,
    output logic                 o_w_pass,
    output logic [2*WIDTH:0]     o_w_err_count,
    output logic [WIDTH-1:0]     o_w_fail_a,
    output logic [WIDTH-1:0]     o_w_fail_b
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int EW = 2 * WIDTH + 1;
    localparam int VW = 2 * WIDTH;

    localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [EW-1:0]    ERR_ONE  = EW'(1);
    localparam logic [VW-1:0]    VEC_ONE  = VW'(1);
    localparam logic [WIDTH-1:0] MAX_V    = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] fail_a_q;
    logic [WIDTH-1:0] fail_b_q;
    logic [EW-1:0]    err_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic [2:0]       golden;
    logic [2:0]       observed;
    logic             mismatch;
    logic             last_vec;
    logic             finish;
    logic [VW-1:0]    vec_d;

    // Golden result for the vector currently on the operand bus; any differing bit flags the vector once.
    always_comb begin
        golden   = {a_q < b_q, a_q > b_q, a_q == b_q};
        observed = {i_w_lt, i_w_gt, i_w_eq};
        mismatch = (observed != golden);
        last_vec = (a_q == MAX_V) && (b_q == MAX_V);
        vec_d    = {a_q, b_q} + VEC_ONE;
`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
        finish   = last_vec || mismatch;
`else
        finish   = last_vec;
`endif
    end

    // Sweep sequencer: apply vector, let it settle, check, advance (b fastest), all outputs registered.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            fail_a_q <= '0;
            fail_b_q <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_w_start) begin
                        state_q  <= S_APPLY;
                        cnt_q    <= '0;
                        a_q      <= '0;
                        b_q      <= '0;
                        fail_a_q <= '0;
                        fail_b_q <= '0;
                        err_q    <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_CHECK;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        // Count can reach at most 2^(2*WIDTH), which the extra bit absorbs.
                        err_q <= err_q + ERR_ONE;
                        if (err_q == '0) begin
                            fail_a_q <= a_q;
                            fail_b_q <= b_q;
                        end
                    end
                    if (finish) begin
                        // Operands stay on the final (or failing) vector.
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !mismatch;
                    end else begin
                        state_q    <= S_APPLY;
                        cnt_q      <= '0;
                        {a_q, b_q} <= vec_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_w_a         = a_q;
    assign o_w_b         = b_q;
    assign o_w_busy      = busy_q;
    assign o_w_done      = done_q;
    assign o_w_pass      = pass_q;
    assign o_w_err_count = err_q;
    assign o_w_fail_a    = fail_a_q;
    assign o_w_fail_b    = fail_b_q;

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: two instances (WIDTH=1/SETTLE=1, WIDTH=2/SETTLE=2) drive a comparator model with per-vector fault masks.
// Latency: n/a (testbench).
// Backpressure: n/a; expected results come from a per-vector fault table walked in sweep order.
module tb_comparator_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, start0, start1;
    logic [0:0] a0, b0, fa0, fb0;
    logic [1:0] a1, b1, fa1, fb1;
    logic       lt0, gt0, eq0, lt1, gt1, eq1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [2:0] err0;
    logic [4:0] err1;

    // Fault table per vector index (a*2^W+b): bits {lt,gt,eq} inverted from the true answer.
    logic [2:0] mask0 [4];
    logic [2:0] mask1 [16];

    assign {lt0, gt0, eq0} = {a0 < b0, a0 > b0, a0 == b0} ^ mask0[{a0, b0}];
    assign {lt1, gt1, eq1} = {a1 < b1, a1 > b1, a1 == b1} ^ mask1[{a1, b1}];

    comparator_bist #(.WIDTH(1), .SETTLE(1)) u_dut0 (
        .i_w_clk(clk), .i_w_reset(rst0), .i_w_start(start0),
        .o_w_a(a0), .o_w_b(b0), .i_w_lt(lt0), .i_w_gt(gt0), .i_w_eq(eq0),
        .o_w_busy(busy0), .o_w_done(done0), .o_w_pass(pass0),
        .o_w_err_count(err0), .o_w_fail_a(fa0), .o_w_fail_b(fb0)
    );

    comparator_bist #(.WIDTH(2), .SETTLE(2)) u_dut1 (
        .i_w_clk(clk), .i_w_reset(rst1), .i_w_start(start1),
        .o_w_a(a1), .o_w_b(b1), .i_w_lt(lt1), .i_w_gt(gt1), .i_w_eq(eq1),
        .o_w_busy(busy1), .o_w_done(done1), .o_w_pass(pass1),
        .o_w_err_count(err1), .o_w_fail_a(fa1), .o_w_fail_b(fb1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    // sel: 0 a, 1 b, 2 busy, 3 done, 4 pass, 5 err_count, 6 fail_a, 7 fail_b
    function automatic int get(input int which, input int sel);
        if (which == 0) begin
            case (sel)
                0: return int'(a0);
                1: return int'(b0);
                2: return int'(busy0);
                3: return int'(done0);
                4: return int'(pass0);
                5: return int'(err0);
                6: return int'(fa0);
                7: return int'(fb0);
                default: return 0;
            endcase
        end else begin
            case (sel)
                0: return int'(a1);
                1: return int'(b1);
                2: return int'(busy1);
                3: return int'(done1);
                4: return int'(pass1);
                5: return int'(err1);
                6: return int'(fa1);
                7: return int'(fb1);
                default: return 0;
            endcase
        end
    endfunction

    function automatic int vec_idx(input int which);
        return (which == 0) ? ((get(0, 0) << 1) | get(0, 1)) : ((get(1, 0) << 2) | get(1, 1));
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 0) start0 = v;
        else            start1 = v;
    endtask

    task automatic set_rst(input int which, input logic v);
        if (which == 0) rst0 = v;
        else            rst1 = v;
    endtask

    task automatic clear_masks();
        foreach (mask0[i]) mask0[i] = 3'b000;
        foreach (mask1[i]) mask1[i] = 3'b000;
    endtask

    task automatic check_all_zero(input int which);
        chk("rst_a",    get(which, 0), 0);
        chk("rst_b",    get(which, 1), 0);
        chk("rst_busy", get(which, 2), 0);
        chk("rst_done", get(which, 3), 0);
        chk("rst_pass", get(which, 4), 0);
        chk("rst_err",  get(which, 5), 0);
        chk("rst_fa",   get(which, 6), 0);
        chk("rst_fb",   get(which, 7), 0);
    endtask

    task automatic pulse_start(input int which);
        @(negedge clk);
        set_start(which, 1'b1);
        @(posedge clk);
        #1;
        set_start(which, 1'b0);
    endtask

    // One full sweep; expectation comes from walking the fault table in (a,b) order.
    task automatic do_sweep(input int which, input bit mid);
        int w, settle, side, n, cnt, first, visited, lat, k, idx, last, order_bad;
        int seen[$];
        logic [2:0] m;
        w      = (which == 0) ? 1 : 2;
        settle = (which == 0) ? 1 : 2;
        side   = 1 << w;
        n      = side * side;
        cnt    = 0;
        first  = -1;
        for (int i = 0; i < n; i++) begin
            if (which == 0) m = mask0[i];
            else            m = mask1[i];
            if (m != 3'b000) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        visited = n;
`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
        if (first >= 0) begin
            visited = first + 1;
            cnt     = 1;
        end
`endif
        lat = visited * (settle + 1);

        pulse_start(which);
        idx = vec_idx(which);
        chk("start_busy", get(which, 2), 1);
        chk("start_done", get(which, 3), 0);
        chk("start_err",  get(which, 5), 0);
        chk("start_vec",  idx, 0);
        seen.push_back(idx);
        last = idx;
        k    = 0;
        while (k < lat + 16) begin
            @(posedge clk);
            #1;
            k++;
            idx = vec_idx(which);
            if (get(which, 2) == 1 && idx != last) begin
                seen.push_back(idx);
                last = idx;
            end
            if (get(which, 3) == 1) break;
            if (mid) set_start(which, ($urandom_range(0, 3) == 0));
        end
        set_start(which, 1'b0);

        chk("latency", k, lat);
        chk("done",    get(which, 3), 1);
        chk("busy",    get(which, 2), 0);
        chk("pass",    get(which, 4), (cnt == 0) ? 1 : 0);
        chk("err",     get(which, 5), cnt);
        chk("fail_a",  get(which, 6), (first >= 0) ? (first >> w) : 0);
        chk("fail_b",  get(which, 7), (first >= 0) ? (first % side) : 0);
        chk("end_a",   get(which, 0), (visited - 1) >> w);
        chk("end_b",   get(which, 1), (visited - 1) % side);
        chk("visited", seen.size(), visited);
        order_bad = 0;
        foreach (seen[i]) if (seen[i] != i) order_bad++;
        chk("order", order_bad, 0);
    endtask

    task automatic reset_mid(input int which);
        int k, idx;
        pulse_start(which);
        k   = 0;
        idx = vec_idx(which);
        while (k < 64 && idx != 2) begin
            @(posedge clk);
            #1;
            k++;
            idx = vec_idx(which);
        end
        chk("reach_v3", idx, 2);
        set_rst(which, 1'b1);
        @(posedge clk);
        #1;
        set_rst(which, 1'b0);
        check_all_zero(which);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        clear_masks();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero(0);
        check_all_zero(1);
        rst0 = 1'b0; rst1 = 1'b0;

        // Golden WIDTH=1 sweep, then done must hold with no start.
        do_sweep(0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", get(0, 3), 1);

        // lt stuck at 0: only (0,1) has a true lt.
        mask0[1] = 3'b100;
        do_sweep(0, 1'b0);
        clear_masks();

        // eq asserted alongside gt at (1,0).
        mask0[2] = 3'b001;
        do_sweep(0, 1'b0);
        clear_masks();

        // gt stuck at 1: wrong everywhere except (1,0).
        mask0[0] = 3'b010; mask0[1] = 3'b010; mask0[3] = 3'b010;
        do_sweep(0, 1'b0);
        clear_masks();

        // Golden WIDTH=2 with start pulses while busy.
        do_sweep(1, 1'b1);

        // Reset in the third vector, then a clean sweep from IDLE.
        reset_mid(1);
        do_sweep(1, 1'b0);

        // Every vector wrong: err_count reaches its ceiling.
        foreach (mask1[i]) mask1[i] = 3'b111;
        do_sweep(1, 1'b0);
        clear_masks();

        // Random fault tables on both instances.
        for (int it = 0; it < 6; it++) begin
            foreach (mask0[i]) mask0[i] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            foreach (mask1[i]) mask1[i] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            do_sweep(0, ($urandom_range(0, 1) == 1));
            do_sweep(1, ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
